// File: rtl/keypad_code_lock_pkg.sv
// Shared definitions for the keypad code lock: FSM state encoding and
// the width helper for the shared down-counter.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } lock_state_e;

    // Bits needed to hold (largest of three cycle counts) - 1.
    function automatic int unsigned clog2_max3(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/keypad_code_lock_if.sv
// Keypad lock bus: debounced keys and code in, lock status out.
interface keypad_code_lock_if #(
    parameter int NUM_KEYS  = 4,
    parameter int CODE_LEN  = 4,
    parameter int MAX_FAILS = 3
);
    localparam int KEY_W  = $clog2(NUM_KEYS);
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    logic [NUM_KEYS-1:0]       key_db;
    logic [CODE_LEN*KEY_W-1:0] code_in;
    logic                      unlocked;
    logic                      fail_pulse;
    logic                      locked_out;
    logic [CNT_W-1:0]          digit_cnt;
    logic [FAIL_W-1:0]         fail_cnt;

    modport master (
        output key_db, code_in,
        input  unlocked, fail_pulse, locked_out, digit_cnt, fail_cnt
    );

    modport slave (
        input  key_db, code_in,
        output unlocked, fail_pulse, locked_out, digit_cnt, fail_cnt
    );

endinterface

// File: rtl/keypad_code_lock_key_press_detect.sv
// Rising-edge detector over the debounced key lines; classifies each
// cycle as no press, a single-key press (with its index) or a multi-key press.
module key_press_detect #(
    parameter int NUM_KEYS = 4
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [NUM_KEYS-1:0]         key_db_i,
    output logic                        press_o,
    output logic                        valid_o,
    output logic [$clog2(NUM_KEYS)-1:0] digit_o
);
    localparam int KEY_W = $clog2(NUM_KEYS);

    logic [NUM_KEYS-1:0] key_prev_q;
    logic [NUM_KEYS-1:0] rise;

    // Reset to all ones so a key held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (srst) key_prev_q <= '1;
        else      key_prev_q <= key_db_i;
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_rise
        assign rise[gi] = key_db_i[gi] & ~key_prev_q[gi];
    end

    assign press_o = |rise;
    assign valid_o = press_o && ((rise & (rise - NUM_KEYS'(1))) == '0);

    always_comb begin
        digit_o = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (rise[i]) digit_o = KEY_W'(i);
        end
    end

endmodule

// File: rtl/keypad_code_lock.sv
// Keypad code lock: collects CODE_LEN digits, opens on a match, counts
// consecutive failures into a timed lockout, and abandons stale partial entries.
module keypad_code_lock
    import lock_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int OPEN_CYCLES    = 250000000,
    parameter int LOCKOUT_CYCLES = 500000000,
    parameter int TIMEOUT_CYCLES = 150000000
) (
    input  logic               MAX10_CLK1_50,
    input  logic               Reset,
    keypad_code_lock_if.slave  lock_if
);
    localparam int KEY_W  = $clog2(NUM_KEYS);
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int TMR_W  = clog2_max3(OPEN_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES);

    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);

    lock_state_e        state_q;
    logic [CNT_W-1:0]   digit_cnt_q;
    logic [FAIL_W-1:0]  fail_cnt_q;
    logic               mismatch_q;
    logic [TMR_W-1:0]   timer_q;
    logic               unlocked_q;
    logic               fail_pulse_q;
    logic               locked_out_q;

    logic               press;
    logic               key_valid;
    logic [KEY_W-1:0]   key_digit;
    logic [KEY_W-1:0]   code_digit [CODE_LEN];
    logic [KEY_W-1:0]   exp_digit;
    logic               digit_bad;
    logic               last_digit;
    logic [FAIL_W-1:0]  fail_cnt_inc;

    key_press_detect #(
        .NUM_KEYS (NUM_KEYS)
    ) u_press (
        .clk      (MAX10_CLK1_50),
        .srst     (Reset),
        .key_db_i (lock_if.key_db),
        .press_o  (press),
        .valid_o  (key_valid),
        .digit_o  (key_digit)
    );

    for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_code
        assign code_digit[gi] = lock_if.code_in[gi*KEY_W +: KEY_W];
    end

    // The expected digit is looked up live, so code_in only matters at press time.
    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (digit_cnt_q == CNT_W'(i)) exp_digit = code_digit[i];
        end
    end

    assign digit_bad    = !key_valid || (key_digit != exp_digit);
    assign last_digit   = (digit_cnt_q == CNT_W'(CODE_LEN - 1));
    assign fail_cnt_inc = fail_cnt_q + FAIL_W'(1);

    always_ff @(posedge MAX10_CLK1_50) begin
        if (Reset) begin
            state_q      <= ST_ENTRY;
            digit_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            mismatch_q   <= 1'b0;
            timer_q      <= TMO_LOAD;
            unlocked_q   <= 1'b0;
            fail_pulse_q <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            fail_pulse_q <= 1'b0;
            case (state_q)
                ST_ENTRY: begin
                    if (press) begin
                        timer_q <= TMO_LOAD;
                        if (last_digit) begin
                            digit_cnt_q <= '0;
                            mismatch_q  <= 1'b0;
                            if (!mismatch_q && !digit_bad) begin
                                state_q    <= ST_OPEN;
                                unlocked_q <= 1'b1;
                                fail_cnt_q <= '0;
                                timer_q    <= OPEN_LOAD;
                            end else begin
                                fail_pulse_q <= 1'b1;
                                fail_cnt_q   <= fail_cnt_inc;
                                if (fail_cnt_inc == FAIL_W'(MAX_FAILS)) begin
                                    state_q      <= ST_LOCKOUT;
                                    locked_out_q <= 1'b1;
                                    timer_q      <= LOCK_LOAD;
                                end
                            end
                        end else begin
                            digit_cnt_q <= digit_cnt_q + CNT_W'(1);
                            mismatch_q  <= mismatch_q | digit_bad;
                        end
                    end else if (digit_cnt_q == '0) begin
                        timer_q <= TMO_LOAD;
                    end else if (timer_q == '0) begin
                        // Stale partial entry: drop it silently.
                        digit_cnt_q <= '0;
                        mismatch_q  <= 1'b0;
                        timer_q     <= TMO_LOAD;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                ST_OPEN: begin
                    if (timer_q == '0) begin
                        state_q    <= ST_ENTRY;
                        unlocked_q <= 1'b0;
                        timer_q    <= TMO_LOAD;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_q == '0) begin
                        state_q      <= ST_ENTRY;
                        locked_out_q <= 1'b0;
                        fail_cnt_q   <= '0;
                        timer_q      <= TMO_LOAD;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_q      <= ST_ENTRY;
                    unlocked_q   <= 1'b0;
                    locked_out_q <= 1'b0;
                    timer_q      <= TMO_LOAD;
                end
            endcase
        end
    end

    assign lock_if.unlocked   = unlocked_q;
    assign lock_if.fail_pulse = fail_pulse_q;
    assign lock_if.locked_out = locked_out_q;
    assign lock_if.digit_cnt  = digit_cnt_q;
    assign lock_if.fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed bench for keypad_code_lock: code 0,0,3,1 with short timing windows.
module tb_keypad_code_lock;

    logic clk;
    logic Reset;
    int   total;
    int   bad;
    int   cnt;

    keypad_code_lock_if #(.NUM_KEYS(4), .CODE_LEN(4), .MAX_FAILS(3)) lif ();

    keypad_code_lock #(
        .NUM_KEYS       (4),
        .CODE_LEN       (4),
        .MAX_FAILS      (3),
        .OPEN_CYCLES    (20),
        .LOCKOUT_CYCLES (40),
        .TIMEOUT_CYCLES (30)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .Reset         (Reset),
        .lock_if       (lif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One idle edge, then a one-cycle key pulse; returns just after the press edge.
    task automatic press(input logic [3:0] mask);
        step(1);
        lif.key_db = mask;
        step(1);
        lif.key_db = '0;
        $display("press keys=%b -> digit_cnt=%0d unlocked=%0b fail_pulse=%0b locked_out=%0b fail_cnt=%0d",
                 mask, lif.digit_cnt, lif.unlocked, lif.fail_pulse, lif.locked_out, lif.fail_cnt);
    endtask

    task automatic correct_entry();
        press(4'b0001); press(4'b0001); press(4'b1000); press(4'b0010);
    endtask

    task automatic wrong_entry();
        press(4'b0001); press(4'b0010); press(4'b1000); press(4'b0010);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        lif.key_db  = '0;
        lif.code_in = 8'h70;   // digits 0,0,3,1 (digit 0 in the low bits)
        step(3);
        chk("rst_unlocked",   lif.unlocked,   0);
        chk("rst_fail_pulse", lif.fail_pulse, 0);
        chk("rst_locked_out", lif.locked_out, 0);
        chk("rst_digit_cnt",  lif.digit_cnt,  0);
        chk("rst_fail_cnt",   lif.fail_cnt,   0);
        Reset = 1'b0;
        step(1);

        // Correct code opens for exactly 20 cycles
        press(4'b0001); chk("t1_cnt1", lif.digit_cnt, 1);
        press(4'b0001); chk("t1_cnt2", lif.digit_cnt, 2);
        press(4'b1000); chk("t1_cnt3", lif.digit_cnt, 3);
        chk("t1_not_yet_open", lif.unlocked, 0);
        press(4'b0010);
        chk("t1_unlocked", lif.unlocked, 1);
        chk("t1_fail_cnt", lif.fail_cnt, 0);
        chk("t1_cnt_clr",  lif.digit_cnt, 0);
        cnt = 0;
        while (lif.unlocked === 1'b1 && cnt < 200) begin cnt++; step(1); end
        chk("t1_open_len", cnt, 20);

        // Wrong code: silent until the 4th digit
        press(4'b0001); press(4'b0010);
        chk("t2_no_early_fail", lif.fail_pulse, 0);
        chk("t2_cnt2", lif.digit_cnt, 2);
        press(4'b1000);
        chk("t2_no_early_fail3", lif.fail_pulse, 0);
        press(4'b0010);
        chk("t2_fail_pulse", lif.fail_pulse, 1);
        chk("t2_fail_cnt",   lif.fail_cnt,   1);
        chk("t2_cnt_clr",    lif.digit_cnt,  0);
        chk("t2_locked",     lif.unlocked,   0);
        step(1);
        chk("t2_pulse_once", lif.fail_pulse, 0);

        // Third consecutive failure locks out for 40 cycles
        wrong_entry();
        chk("t3_fail_cnt2", lif.fail_cnt, 2);
        chk("t3_not_locked", lif.locked_out, 0);
        wrong_entry();
        chk("t3_fail_pulse", lif.fail_pulse, 1);
        chk("t3_locked_out", lif.locked_out, 1);
        chk("t3_fail_cnt3",  lif.fail_cnt,   3);
        press(4'b0001);
        chk("t3_press_ignored", lif.digit_cnt, 0);
        chk("t3_still_locked",  lif.locked_out, 1);
        cnt = 2;
        while (lif.locked_out === 1'b1 && cnt < 200) begin cnt++; step(1); end
        chk("t3_lockout_len", cnt, 40);
        chk("t3_fail_cnt_clr", lif.fail_cnt, 0);

        // Stale partial entry times out without counting a failure
        wrong_entry();
        chk("t4_fail_cnt1", lif.fail_cnt, 1);
        press(4'b0001); press(4'b0001);
        chk("t4_cnt2", lif.digit_cnt, 2);
        cnt = 0;
        while (lif.digit_cnt !== '0 && cnt < 200) begin cnt++; step(1); end
        chk("t4_timeout_len", cnt, 30);
        chk("t4_fail_cnt_kept", lif.fail_cnt, 1);
        correct_entry();
        chk("t4_unlocked", lif.unlocked, 1);
        chk("t4_fail_cnt_clr", lif.fail_cnt, 0);
        cnt = 0;
        while (lif.unlocked === 1'b1 && cnt < 200) begin cnt++; step(1); end
        chk("t4_open_len", cnt, 20);

        // Two keys rising together count as a digit that never matches
        press(4'b0001); press(4'b0101);
        chk("t5_cnt2", lif.digit_cnt, 2);
        chk("t5_no_early_fail", lif.fail_pulse, 0);
        press(4'b1000); press(4'b0010);
        chk("t5_fail_pulse", lif.fail_pulse, 1);
        chk("t5_unlocked",   lif.unlocked,   0);
        chk("t5_fail_cnt",   lif.fail_cnt,   1);

        // Code changed mid-entry affects only the remaining digits
        press(4'b0001);
        lif.code_in = 8'hA8;   // digits 0,2,2,2
        press(4'b0100); press(4'b0100); press(4'b0100);
        chk("t7_unlocked", lif.unlocked, 1);
        lif.code_in = 8'h70;

        // Key held through reset, and reset while open
        lif.key_db = 4'b1000;
        Reset = 1'b1;
        step(2);
        chk("t6_rst_unlocked", lif.unlocked, 0);
        chk("t6_rst_fail_cnt", lif.fail_cnt, 0);
        Reset = 1'b0;
        step(3);
        chk("t6_held_no_press", lif.digit_cnt, 0);
        lif.key_db = '0;
        step(1);
        lif.key_db = 4'b1000;
        step(1);
        lif.key_db = '0;
        chk("t6_repress", lif.digit_cnt, 1);
        press(4'b0001); press(4'b1000); press(4'b0010);
        chk("t6_fail_pulse", lif.fail_pulse, 1);
        chk("t6_fail_cnt",   lif.fail_cnt,   1);
        correct_entry();
        chk("t8_unlocked", lif.unlocked, 1);
        step(5);
        Reset = 1'b1;
        step(1);
        chk("t8_rst_unlocked", lif.unlocked, 0);
        Reset = 1'b0;
        step(2);
        chk("t8_stays_closed", lif.unlocked, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
